// File: rtl/bmem_arbiter.sv
// ---------------------------------------------------------------------------
// bmem_arbiter
//
// Shares the single burst-memory port (bmem) between the I-cache and D-cache
// DFP ports. Only one line transaction is in flight at a time.
//   - Line writes are split into BEATS beats of BEAT_W bits, lowest beat first.
//   - Line reads are rebuilt from BEATS returning beats. A beat is kept only
//     when its address tag matches the line being fetched.
//
// Optional feature (compile-time macro ARB_ROUND_ROBIN_EN):
//   undefined : fixed priority, the D-cache wins over the I-cache.
//   defined   : when both ports request at once, the port that was not granted
//               last wins. The grant register holds the last grant (reset = D).
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   ic_dfp_addr/read/write/wdata I-cache line request (held until resp)
//   ic_dfp_rdata/resp            I-cache line result, resp is a 1-cycle pulse
//   dc_dfp_*                     same set for the D-cache
//   bmem_addr/read/write/wdata   burst command and write beats to bmem
//   bmem_ready                   bmem accepts the command or beat this cycle
//   bmem_raddr/rdata/rvalid      returning read beats with their address tag
//
// Every output is driven straight from a flop. The next output values are
// worked out from the next-state values, so the outputs line up with the
// state register.
// ---------------------------------------------------------------------------
module bmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] ic_dfp_addr,
  input  logic              ic_dfp_read,
  input  logic              ic_dfp_write,
  input  logic [LINE_W-1:0] ic_dfp_wdata,
  output logic [LINE_W-1:0] ic_dfp_rdata,
  output logic              ic_dfp_resp,

  input  logic [ADDR_W-1:0] dc_dfp_addr,
  input  logic              dc_dfp_read,
  input  logic              dc_dfp_write,
  input  logic [LINE_W-1:0] dc_dfp_wdata,
  output logic [LINE_W-1:0] dc_dfp_rdata,
  output logic              dc_dfp_resp,

  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);   // byte-offset bits within a line
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_BURST = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  typedef enum logic {
    GNT_D = 1'b0,
    GNT_I = 1'b1
  } grant_t;

  // Transaction state
  state_t            r_state,    w_state_next;
  logic [CNT_W-1:0]  r_cnt,      w_cnt_next;
  logic [ADDR_W-1:0] r_addr,     w_addr_next;
  logic [LINE_W-1:0] r_line,     w_line_next;
  grant_t            r_grant,    w_grant_next;
  logic              r_is_write, w_is_write_next;

  // Output flops
  logic [ADDR_W-1:0] r_bmem_addr,  w_bmem_addr_next;
  logic              r_bmem_read,  w_bmem_read_next;
  logic              r_bmem_write, w_bmem_write_next;
  logic [BEAT_W-1:0] r_bmem_wdata, w_bmem_wdata_next;
  logic              r_ic_resp,    w_ic_resp_next;
  logic              r_dc_resp,    w_dc_resp_next;
  logic [LINE_W-1:0] r_ic_rdata,   w_ic_rdata_next;
  logic [LINE_W-1:0] r_dc_rdata,   w_dc_rdata_next;

  // Requester selection
  logic              w_d_req;
  logic              w_i_req;
  logic              w_pick_d;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_write;
  logic [LINE_W-1:0] w_sel_wdata;

  assign w_d_req = dc_dfp_read | dc_dfp_write;
  assign w_i_req = ic_dfp_read | ic_dfp_write;

`ifdef ARB_ROUND_ROBIN_EN
  // D wins when it is alone, or when I held the previous grant.
  assign w_pick_d = w_d_req && (!w_i_req || (r_grant == GNT_I));
`else
  assign w_pick_d = w_d_req;
`endif

  assign w_sel_addr  = w_pick_d ? dc_dfp_addr  : ic_dfp_addr;
  assign w_sel_write = w_pick_d ? dc_dfp_write : ic_dfp_write;
  assign w_sel_wdata = w_pick_d ? dc_dfp_wdata : ic_dfp_wdata;

  // Next-state logic
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_addr_next     = r_addr;
    w_line_next     = r_line;
    w_grant_next    = r_grant;
    w_is_write_next = r_is_write;

    case (r_state)
      S_IDLE: begin
        if (w_d_req || w_i_req) begin
          w_grant_next    = w_pick_d ? GNT_D : GNT_I;
          w_addr_next     = {w_sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          w_line_next     = w_sel_wdata;
          w_is_write_next = w_sel_write;
          w_cnt_next      = '0;
          // Write takes precedence when a port raises both read and write.
          w_state_next    = w_sel_write ? S_WR_BURST : S_RD_REQ;
        end
      end

      S_RD_REQ: begin
        if (bmem_ready) begin
          w_state_next = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        // Beats tagged with another line belong to somebody else: drop them.
        if (bmem_rvalid && (bmem_raddr == r_addr)) begin
          w_line_next[BEAT_W*r_cnt +: BEAT_W] = bmem_rdata;
          if (r_cnt == LAST_BEAT) begin
            w_cnt_next   = '0;
            w_state_next = S_RESP;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end

      S_WR_BURST: begin
        if (bmem_ready) begin
          if (r_cnt == LAST_BEAT) begin
            w_cnt_next   = '0;
            w_state_next = S_RESP;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end

      S_RESP: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, taken from the next state
  always_comb begin
    w_bmem_read_next  = (w_state_next == S_RD_REQ);
    w_bmem_write_next = (w_state_next == S_WR_BURST);
    w_bmem_addr_next  = '0;
    w_bmem_wdata_next = '0;
    w_ic_resp_next    = 1'b0;
    w_dc_resp_next    = 1'b0;
    w_ic_rdata_next   = '0;
    w_dc_rdata_next   = '0;

    if ((w_state_next == S_RD_REQ) || (w_state_next == S_WR_BURST)) begin
      w_bmem_addr_next = w_addr_next;
    end
    if (w_state_next == S_WR_BURST) begin
      w_bmem_wdata_next = w_line_next[BEAT_W*w_cnt_next +: BEAT_W];
    end
    if (w_state_next == S_RESP) begin
      if (w_grant_next == GNT_D) begin
        w_dc_resp_next = 1'b1;
        if (!w_is_write_next) begin
          w_dc_rdata_next = w_line_next;
        end
      end else begin
        w_ic_resp_next = 1'b1;
        if (!w_is_write_next) begin
          w_ic_rdata_next = w_line_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_line       <= '0;
      r_grant      <= GNT_D;
      r_is_write   <= 1'b0;
      r_bmem_addr  <= '0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_bmem_wdata <= '0;
      r_ic_resp    <= 1'b0;
      r_dc_resp    <= 1'b0;
      r_ic_rdata   <= '0;
      r_dc_rdata   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_addr       <= w_addr_next;
      r_line       <= w_line_next;
      r_grant      <= w_grant_next;
      r_is_write   <= w_is_write_next;
      r_bmem_addr  <= w_bmem_addr_next;
      r_bmem_read  <= w_bmem_read_next;
      r_bmem_write <= w_bmem_write_next;
      r_bmem_wdata <= w_bmem_wdata_next;
      r_ic_resp    <= w_ic_resp_next;
      r_dc_resp    <= w_dc_resp_next;
      r_ic_rdata   <= w_ic_rdata_next;
      r_dc_rdata   <= w_dc_rdata_next;
    end
  end

  assign bmem_addr    = r_bmem_addr;
  assign bmem_read    = r_bmem_read;
  assign bmem_write   = r_bmem_write;
  assign bmem_wdata   = r_bmem_wdata;
  assign ic_dfp_resp  = r_ic_resp;
  assign dc_dfp_resp  = r_dc_resp;
  assign ic_dfp_rdata = r_ic_rdata;
  assign dc_dfp_rdata = r_dc_rdata;

endmodule
